// File: rtl/control_sequencer_pkg.sv
// Shared opcode, ALU code, state and instruction-class definitions for the
// hardwired control unit.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_NONE = 5'b00000;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_HALT = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU,
        CLS_IMM,
        CLS_MD,
        CLS_NOP,
        CLS_HALT
    } instr_class_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Strobe bundle between the control unit (master) and the datapath (slave).
interface control_sequencer_if;
    logic        run;
    logic        mem_rdy;
    logic [31:0] IR;
    logic [15:0] R_rd;
    logic [15:0] R_wrt;
    logic        PC_out, MDR_out, Zlo_out, Zhi_out, C_out;
    logic        PC_rd, MAR_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, Zhi_rd, HI_rd, LO_rd;
    logic        IncPC, Read;
    logic [4:0]  op_sel;
    logic        halted;
    logic [3:0]  state;

    modport master (
        input  run, mem_rdy, IR,
        output R_rd, R_wrt, PC_out, MDR_out, Zlo_out, Zhi_out, C_out,
               PC_rd, MAR_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, Zhi_rd, HI_rd, LO_rd,
               IncPC, Read, op_sel, halted, state
    );

    modport slave (
        output run, mem_rdy, IR,
        input  R_rd, R_wrt, PC_out, MDR_out, Zlo_out, Zhi_out, C_out,
               PC_rd, MAR_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, Zhi_rd, HI_rd, LO_rd,
               IncPC, Read, op_sel, halted, state
    );
endinterface

// File: rtl/control_sequencer_decode.sv
// Combinational instruction decode: class, effective ALU code and one-hot
// register selects from the IR fields.
module ctrl_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [31:0]  ir,
    output instr_class_t cls,
    output logic [4:0]   op_sel_eff,
    output logic [15:0]  ra_sel,
    output logic [15:0]  rb_sel,
    output logic [15:0]  rc_sel
);
    logic [4:0] op;
    logic       unused_imm;

    assign op         = ir[31:27];
    assign ra_sel     = 16'b1 << ir[26:23];
    assign rb_sel     = 16'b1 << ir[22:19];
    assign rc_sel     = 16'b1 << ir[18:15];
    // Low constant bits flow through the datapath, not the control unit.
    assign unused_imm = ^ir[14:0];

    always_comb begin
        cls        = CLS_NOP;
        op_sel_eff = ALU_NONE;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA,
            OP_SHL, OP_ROR, OP_ROL: begin
                cls        = CLS_ALU;
                op_sel_eff = op;
            end
            OP_ADDI: begin
                cls        = CLS_IMM;
                op_sel_eff = OP_ADD;
            end
            OP_ANDI: begin
                cls        = CLS_IMM;
                op_sel_eff = OP_AND;
            end
            OP_ORI: begin
                cls        = CLS_IMM;
                op_sel_eff = OP_OR;
            end
            OP_MUL, OP_DIV: begin
                cls        = CLS_MD;
                op_sel_eff = op;
            end
            OP_HALT: cls = CLS_HALT;
            default: cls = CLS_NOP;
        endcase
    end
endmodule

// File: rtl/control_sequencer.sv
// Hardwired fetch/execute sequencer: state register, next-state logic and
// per-state strobe decode for the datapath.
module control_sequencer
    import cpu_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                clr,
    control_sequencer_if.master bus
);
    state_t       state_q, state_d;
    instr_class_t cls;
    logic [4:0]   op_sel_eff;
    logic [15:0]  ra_sel, rb_sel, rc_sel;

    ctrl_decode u_decode (
        .ir         (bus.IR),
        .cls        (cls),
        .op_sel_eff (op_sel_eff),
        .ra_sel     (ra_sel),
        .rb_sel     (rb_sel),
        .rc_sel     (rc_sel)
    );

    always_ff @(posedge clk) begin
        if (clr) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.run) state_d = ST_T0;
            ST_T0:   state_d = ST_T1;
            ST_T1:   if (bus.mem_rdy) state_d = ST_T2;
            ST_T2: begin
                case (cls)
                    CLS_NOP:  state_d = ST_T0;
                    CLS_HALT: state_d = ST_HALT;
                    default:  state_d = ST_T3;
                endcase
            end
            ST_T3:   state_d = ST_T4;
            ST_T4:   state_d = ST_T5;
            ST_T5:   state_d = (cls == CLS_MD) ? ST_T6 : ST_T0;
            ST_T6:   state_d = ST_T0;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.state = state_q;

    always_comb begin
        bus.R_rd    = '0;
        bus.R_wrt   = '0;
        bus.PC_out  = 1'b0;
        bus.MDR_out = 1'b0;
        bus.Zlo_out = 1'b0;
        bus.Zhi_out = 1'b0;
        bus.C_out   = 1'b0;
        bus.PC_rd   = 1'b0;
        bus.MAR_rd  = 1'b0;
        bus.MDR_rd  = 1'b0;
        bus.IR_rd   = 1'b0;
        bus.Y_rd    = 1'b0;
        bus.Zlo_rd  = 1'b0;
        bus.Zhi_rd  = 1'b0;
        bus.HI_rd   = 1'b0;
        bus.LO_rd   = 1'b0;
        bus.IncPC   = 1'b0;
        bus.Read    = 1'b0;
        bus.op_sel  = ALU_NONE;
        bus.halted  = 1'b0;
        case (state_q)
            ST_T0: begin
                bus.PC_out = 1'b1;
                bus.MAR_rd = 1'b1;
                bus.IncPC  = 1'b1;
            end
            ST_T1: begin
                bus.Read   = 1'b1;
                bus.MDR_rd = bus.mem_rdy;
            end
            ST_T2: begin
                bus.MDR_out = 1'b1;
                bus.IR_rd   = 1'b1;
            end
            ST_T3: begin
                bus.R_wrt = rb_sel;
                bus.Y_rd  = 1'b1;
            end
            ST_T4: begin
                bus.op_sel = op_sel_eff;
                bus.Zlo_rd = 1'b1;
                bus.Zhi_rd = (cls == CLS_MD);
                // Immediate forms take the second operand from the constant field.
                if (cls == CLS_IMM) bus.C_out = 1'b1;
                else                bus.R_wrt = rc_sel;
            end
            ST_T5: begin
                bus.Zlo_out = 1'b1;
                if (cls == CLS_MD) bus.LO_rd = 1'b1;
                else               bus.R_rd  = ra_sel;
            end
            ST_T6: begin
                bus.Zhi_out = 1'b1;
                bus.HI_rd   = 1'b1;
            end
            ST_HALT: bus.halted = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: directed and random instruction streams checked cycle
// by cycle against an expected-strobe list built from the instruction rules.
module tb_control_sequencer;

    typedef struct packed {
        logic        halted;
        logic [3:0]  st;
        logic [4:0]  op_sel;
        logic [15:0] R_rd;
        logic [15:0] R_wrt;
        logic PC_out, MDR_out, Zlo_out, Zhi_out, C_out;
        logic PC_rd, MAR_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, Zhi_rd, HI_rd, LO_rd;
        logic IncPC, Read;
    } ov_t;

    localparam int K_ALU = 0, K_IMM = 1, K_MD = 2, K_NOP = 3, K_HALT = 4;

    logic clk = 1'b0;
    logic clr;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    control_sequencer_if bus ();

    control_sequencer dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.master)
    );

    function automatic ov_t observe();
        ov_t o;
        o.halted  = bus.halted;   o.st      = bus.state;   o.op_sel = bus.op_sel;
        o.R_rd    = bus.R_rd;     o.R_wrt   = bus.R_wrt;
        o.PC_out  = bus.PC_out;   o.MDR_out = bus.MDR_out; o.Zlo_out = bus.Zlo_out;
        o.Zhi_out = bus.Zhi_out;  o.C_out   = bus.C_out;   o.PC_rd  = bus.PC_rd;
        o.MAR_rd  = bus.MAR_rd;   o.MDR_rd  = bus.MDR_rd;  o.IR_rd  = bus.IR_rd;
        o.Y_rd    = bus.Y_rd;     o.Zlo_rd  = bus.Zlo_rd;  o.Zhi_rd = bus.Zhi_rd;
        o.HI_rd   = bus.HI_rd;    o.LO_rd   = bus.LO_rd;   o.IncPC  = bus.IncPC;
        o.Read    = bus.Read;
        return o;
    endfunction

    function automatic int classify(input logic [4:0] op);
        if (op >= 5'd3 && op <= 5'd11) return K_ALU;
        if (op >= 5'd12 && op <= 5'd14) return K_IMM;
        if (op == 5'd15 || op == 5'd16) return K_MD;
        if (op == 5'd27) return K_HALT;
        return K_NOP;
    endfunction

    function automatic logic [4:0] alu_code(input logic [4:0] op);
        case (op)
            5'd12:   return 5'd3;
            5'd13:   return 5'd5;
            5'd14:   return 5'd6;
            default: return op;
        endcase
    endfunction

    function automatic logic [31:0] mk_ir(input logic [4:0] op, input int ra, input int rb, input int rc);
        logic [14:0] low;
        low = 15'($urandom);
        return {op, 4'(ra), 4'(rb), 4'(rc), low};
    endfunction

    // Compare observed strobes at the mid-cycle point, plus the bus invariant.
    task automatic check_cycle(input ov_t e, input string tag);
        ov_t o;
        int  drv;
        o = observe();
        n_assert++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
        drv = $countones(o.R_wrt) + int'(o.PC_out) + int'(o.MDR_out) + int'(o.Zlo_out)
            + int'(o.Zhi_out) + int'(o.C_out);
        n_assert++;
        assert (drv <= 1) else begin
            n_fail++;
            $error("FAIL %s bus_onehot: observed %0d drivers expected at most 1", tag, drv);
        end
    endtask

    task automatic step_idle(input string tag);
        ov_t z;
        z = '0;
        @(negedge clk);
        check_cycle(z, tag);
        @(posedge clk); #1;
    endtask

    // Starts in T0; leaves in T0 of the next instruction, HALT, or T0 after a
    // reset-and-restart when clr_t4 is set for an executing instruction.
    task automatic exec_instr(input logic [31:0] ir, input int waits, input bit clr_t4, input string name);
        ov_t q[$];
        ov_t e;
        int  k;
        k = classify(ir[31:27]);
        e = '0; e.st = 4'd1; e.PC_out = 1; e.MAR_rd = 1; e.IncPC = 1; q.push_back(e);
        for (int w = 0; w < waits; w++) begin
            e = '0; e.st = 4'd2; e.Read = 1; q.push_back(e);
        end
        e = '0; e.st = 4'd2; e.Read = 1; e.MDR_rd = 1; q.push_back(e);
        e = '0; e.st = 4'd3; e.MDR_out = 1; e.IR_rd = 1; q.push_back(e);
        if (k == K_ALU || k == K_IMM || k == K_MD) begin
            e = '0; e.st = 4'd4; e.R_wrt = 16'd1 << ir[22:19]; e.Y_rd = 1; q.push_back(e);
            e = '0; e.st = 4'd5; e.op_sel = alu_code(ir[31:27]); e.Zlo_rd = 1;
            if (k == K_IMM) e.C_out = 1; else e.R_wrt = 16'd1 << ir[18:15];
            if (k == K_MD) e.Zhi_rd = 1;
            q.push_back(e);
            e = '0; e.st = 4'd6; e.Zlo_out = 1;
            if (k == K_MD) e.LO_rd = 1; else e.R_rd = 16'd1 << ir[26:23];
            q.push_back(e);
            if (k == K_MD) begin
                e = '0; e.st = 4'd7; e.Zhi_out = 1; e.HI_rd = 1; q.push_back(e);
            end
        end
        bus.IR = ir;
        for (int i = 0; i < q.size(); i++) begin
            bus.mem_rdy = (q[i].st == 4'd2) ? q[i].MDR_rd : 1'($urandom);
            bus.run     = 1'($urandom);
            clr         = clr_t4 && (q[i].st == 4'd5);
            @(negedge clk);
            check_cycle(q[i], $sformatf("%s c%0d", name, i));
            @(posedge clk); #1;
            if (clr) begin
                clr     = 1'b0;
                bus.run = 1'b1;
                step_idle({name, " idle_after_clr"});
                return;
            end
        end
    endtask

    initial begin
        ov_t e;
        logic [4:0] op;
        clr = 1'b1;
        bus.run = 1'b0;
        bus.mem_rdy = 1'b0;
        bus.IR = '0;
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        bus.run = 1'b1;
        step_idle("reset");

        exec_instr(32'h2A2B8000, 0, 1'b0, "and_r4_r5_r7");
        exec_instr(mk_ir(5'b01001, 1, 2, 3), 3, 1'b0, "shl_wait3");
        exec_instr(mk_ir(5'b01100, 2, 3, 9), 0, 1'b0, "addi_r2_r3");
        exec_instr(mk_ir(5'b01111, 0, 14, 15), 1, 1'b0, "mul");
        exec_instr(mk_ir(5'b10101, 6, 6, 6), 0, 1'b0, "undef_10101");
        exec_instr(mk_ir(5'b11010, 0, 0, 0), 2, 1'b0, "nop");
        exec_instr(mk_ir(5'b10000, 0, 15, 0), 0, 1'b0, "div_r0");
        exec_instr(mk_ir(5'b00011, 8, 9, 10), 0, 1'b1, "add_clr_t4");

        for (int n = 0; n < 60; n++) begin
            op = 5'($urandom_range(0, 31));
            if (op == 5'd27) op = 5'd26;
            exec_instr(mk_ir(op, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15)),
                       $urandom_range(0, 3), ($urandom_range(0, 9) == 0),
                       $sformatf("rnd%0d_op%0d", n, op));
        end

        exec_instr(mk_ir(5'b11011, 0, 0, 0), 1, 1'b0, "halt");
        e = '0; e.st = 4'd8; e.halted = 1;
        for (int i = 0; i < 20; i++) begin
            bus.run = 1'b1;
            bus.mem_rdy = 1'($urandom);
            @(negedge clk);
            check_cycle(e, $sformatf("halted c%0d", i));
            @(posedge clk); #1;
        end
        clr = 1'b1;
        @(negedge clk);
        check_cycle(e, "halted_at_clr");
        @(posedge clk); #1;
        clr = 1'b0;
        bus.run = 1'b0;
        step_idle("idle_after_halt");
        step_idle("idle_run_low");
        bus.run = 1'b1;
        step_idle("idle_run_high");
        exec_instr(mk_ir(5'b00110, 11, 12, 13), 0, 1'b0, "or_after_halt");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
